// File: rtl/m_axil_fsb_adapter.sv
`default_nettype none
// ============================================================================
// Module   : m_axil_fsb_adapter
// Function : Pushes 80-bit FSB packets into a host-memory mailbox of 128-bit
//            slots as four AXI-Lite single-beat writes (flag word last).
// Revision : 1.0
// ============================================================================
module m_axil_fsb_adapter #(
    parameter int          fsb_width_p = 80,
    parameter logic [31:0] base_addr_p = 32'h0000_0000,
    parameter int          num_slots_p = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           fsb_v_i,
    input  logic [fsb_width_p-1:0]         fsb_data_i,
    output logic                           fsb_ready_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,
    output logic [31:0]                    m_axil_awaddr_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,
    output logic [31:0]                    m_axil_wdata_o,
    output logic [3:0]                     m_axil_wstrb_o,
    input  logic                           m_axil_bvalid_i,
    input  logic [1:0]                     m_axil_bresp_i,
    output logic                           m_axil_bready_o,
    output logic [$clog2(num_slots_p)-1:0] slot_idx_o,
    output logic [31:0]                    pkt_cnt_o,
    output logic [15:0]                    err_cnt_o,
    output logic                           busy_o
);

    localparam int c_SLOT_W = $clog2(num_slots_p);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [fsb_width_p-1:0]   r_data;
    logic [1:0]               r_word;
    logic                     r_aw_done;
    logic                     r_w_done;
    logic [c_SLOT_W-1:0]      r_slot;
    logic [31:0]              r_pkt_cnt;
    logic [15:0]              r_err_cnt;
    logic                     w_aw_fire;
    logic                     w_w_fire;
    logic                     w_b_fire;
    logic [31:0]              w_addr;
    logic [31:0]              w_wdata;

    assign w_aw_fire = (r_state == S_SEND) && !r_aw_done && m_axil_awready_i;
    assign w_w_fire  = (r_state == S_SEND) && !r_w_done  && m_axil_wready_i;
    assign w_b_fire  = (r_state == S_RESP) && m_axil_bvalid_i;

    assign w_addr = base_addr_p + 32'({r_slot, 4'b0000}) + 32'({r_word, 2'b00});

    always_comb begin
        w_wdata = 32'h0000_0001;
        case (r_word)
            2'd0:    w_wdata = r_data[31:0];
            2'd1:    w_wdata = r_data[63:32];
            2'd2:    w_wdata = {16'h0000, r_data[79:64]};
            default: w_wdata = 32'h0000_0001;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are forced to zero combinationally while reset_i is held.
    always_comb begin
        w_state_nxt      = r_state;
        fsb_ready_o      = 1'b0;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        m_axil_awaddr_o  = 32'h0;
        m_axil_wdata_o   = 32'h0;
        m_axil_wstrb_o   = 4'h0;
        busy_o           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fsb_v_i) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axil_bvalid_i) begin
                    w_state_nxt = (r_word == 2'd3) ? S_IDLE : S_SEND;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!reset_i) begin
            fsb_ready_o      = (r_state == S_IDLE);
            busy_o           = (r_state != S_IDLE);
            m_axil_awvalid_o = (r_state == S_SEND) && !r_aw_done;
            m_axil_wvalid_o  = (r_state == S_SEND) && !r_w_done;
            m_axil_bready_o  = (r_state == S_RESP);
            if (r_state != S_IDLE) begin
                m_axil_awaddr_o = w_addr;
                m_axil_wdata_o  = w_wdata;
                m_axil_wstrb_o  = 4'hF;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data    <= '0;
            r_word    <= 2'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_slot    <= '0;
            r_pkt_cnt <= 32'd0;
            r_err_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fsb_v_i) begin
                        r_data    <= fsb_data_i;
                        r_word    <= 2'd0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_aw_fire) r_aw_done <= 1'b1;
                    if (w_w_fire)  r_w_done  <= 1'b1;
                end
                S_RESP: begin
                    if (w_b_fire) begin
                        if ((m_axil_bresp_i != 2'b00) && (r_err_cnt != 16'hFFFF)) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        if (r_word != 2'd3) begin
                            r_word    <= r_word + 2'd1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_slot    <= r_slot + 1'b1;
                            r_pkt_cnt <= r_pkt_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        slot_idx_o = '0;
        pkt_cnt_o  = 32'd0;
        err_cnt_o  = 16'd0;
        if (!reset_i) begin
            slot_idx_o = r_slot;
            pkt_cnt_o  = r_pkt_cnt;
            err_cnt_o  = r_err_cnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_axil_fsb_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_axil_fsb_adapter
// Function : Scoreboard bench for m_axil_fsb_adapter with an AXI-Lite slave model.
// Revision : 1.0
// ============================================================================
module tb_m_axil_fsb_adapter;

    localparam logic [31:0] c_BASE  = 32'h0000_1000;
    localparam int          c_SLOTS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fsb_v = 1'b0;
    logic [79:0] fsb_data = 80'h0;
    logic        fsb_ready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, busy;
    logic [31:0] awaddr, wdata, pkt_cnt;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [1:0]  slot_idx;
    logic [15:0] err_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [1:0]  bresp_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];

    int          n_total = 0;
    int          n_bad   = 0;
    int          aw_lat  = 0;
    int          w_lat   = 0;
    int          b_lat   = 0;
    int          b_total = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          m_slot  = 0;
    int          m_words = 0;
    logic [31:0] m_pkt   = 32'd0;
    logic [15:0] m_err   = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    m_axil_fsb_adapter #(
        .fsb_width_p (80),
        .base_addr_p (c_BASE),
        .num_slots_p (c_SLOTS)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .fsb_v_i          (fsb_v),
        .fsb_data_i       (fsb_data),
        .fsb_ready_o      (fsb_ready),
        .m_axil_awvalid_o (awvalid),
        .m_axil_awready_i (awready),
        .m_axil_awaddr_o  (awaddr),
        .m_axil_wvalid_o  (wvalid),
        .m_axil_wready_i  (wready),
        .m_axil_wdata_o   (wdata),
        .m_axil_wstrb_o   (wstrb),
        .m_axil_bvalid_i  (bvalid),
        .m_axil_bresp_i   (bresp),
        .m_axil_bready_o  (bready),
        .slot_idx_o       (slot_idx),
        .pkt_cnt_o        (pkt_cnt),
        .err_cnt_o        (err_cnt),
        .busy_o           (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic add_bresp(input logic [1:0] r);
        bresp_q.push_back(r);
        if (r != 2'b00 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    endtask

    // Drives one packet, holds fsb_v until accepted, and records the expected writes.
    task automatic fsb_send(input logic [79:0] d);
        int  t;
        wr_t e;
        t        = 0;
        fsb_data = d;
        fsb_v    = 1'b1;
        while (!fsb_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!fsb_ready) begin
            check_val("fsb_accept_timeout", 32'd0, 32'd1);
            return;
        end
        for (int w = 0; w < 4; w++) begin
            e.a = c_BASE + 32'(m_slot * 16) + 32'(w * 4);
            case (w)
                0:       e.d = d[31:0];
                1:       e.d = d[63:32];
                2:       e.d = {16'h0000, d[79:64]};
                default: e.d = 32'h0000_0001;
            endcase
            exp_q.push_back(e);
        end
        m_slot  = (m_slot + 1) % c_SLOTS;
        m_pkt   = m_pkt + 32'd1;
        m_words = m_words + 4;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() > 0 || pkt_cnt != m_pkt || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check_val({tag, "_pkt"},   pkt_cnt, m_pkt);
        check_val({tag, "_slot"},  32'(slot_idx), 32'(m_slot));
        check_val({tag, "_err"},   32'(err_cnt), 32'(m_err));
        check_val({tag, "_bcnt"},  32'(b_total), 32'(m_words));
        check_val({tag, "_sbq"},   32'(exp_q.size()), 32'd0);
        check_val({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        fsb_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ctl", 32'({fsb_ready, awvalid, wvalid, bready, busy}), 32'd0);
        check_val("rst_awaddr", awaddr, 32'd0);
        check_val("rst_wdata", wdata, 32'd0);
        check_val("rst_wstrb", 32'(wstrb), 32'd0);
        check_val("rst_slot", 32'(slot_idx), 32'd0);
        check_val("rst_pkt", pkt_cnt, 32'd0);
        check_val("rst_err", 32'(err_cnt), 32'd0);
        exp_q.delete();
        bresp_q.delete();
        m_slot  = 0;
        m_pkt   = 32'd0;
        m_err   = 16'd0;
        m_words = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready_after", 32'(fsb_ready), 32'd1);
    endtask

    // AXI-Lite slave: readies/B driven at negedge, handshakes land on the next posedge.
    initial begin : p_slave
        int          aw_n, w_n, b_n, pend, pend_new;
        logic        b_fire, aw_wait, w_wait, aw_hs, w_hs;
        logic [31:0] aw_prev, w_prev, a, d;
        wr_t         e;
        aw_n = 0; w_n = 0; b_n = 0; pend = 0; pend_new = 0;
        b_fire = 0; aw_wait = 0; w_wait = 0; aw_hs = 0; w_hs = 0;
        aw_prev = 0; w_prev = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_n = 0; w_n = 0; b_n = 0; pend = 0; pend_new = 0;
                b_fire = 0; aw_wait = 0; w_wait = 0; aw_hs = 0; w_hs = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
                b_total = 0;
                aw_q.delete();
                w_q.delete();
            end else begin
                check_val("rdy_vs_busy", 32'(fsb_ready), 32'(!busy));
                if (b_fire) begin
                    bvalid = 0;
                    b_fire = 0;
                    b_total++;
                end
                pend     = pend + pend_new;
                pend_new = 0;
                if (!bvalid && pend > 0) begin
                    if (b_n >= b_lat) begin
                        bvalid = 1;
                        if (bresp_q.size() > 0) bresp = bresp_q.pop_front();
                        else                    bresp = 2'b00;
                        pend--;
                        b_n = 0;
                    end else begin
                        b_n++;
                    end
                end
                if (bvalid && bready) b_fire = 1;

                if (aw_hs) check_val("aw_drop", 32'(awvalid), 32'd0);
                if (aw_wait) begin
                    check_val("aw_hold", 32'(awvalid), 32'd1);
                    check_val("aw_stable", awaddr, aw_prev);
                end
                awready = 0; aw_hs = 0; aw_wait = 0;
                if (awvalid) begin
                    if (aw_n >= aw_lat) begin
                        awready = 1; aw_hs = 1; aw_n = 0;
                        aw_q.push_back(awaddr);
                    end else begin
                        aw_wait = 1; aw_prev = awaddr; aw_n++;
                    end
                end

                if (w_hs) check_val("w_drop", 32'(wvalid), 32'd0);
                if (w_wait) begin
                    check_val("w_hold", 32'(wvalid), 32'd1);
                    check_val("w_stable", wdata, w_prev);
                end
                wready = 0; w_hs = 0; w_wait = 0;
                if (wvalid) begin
                    if (w_n >= w_lat) begin
                        wready = 1; w_hs = 1; w_n = 0;
                        check_val("wstrb", 32'(wstrb), 32'hF);
                        w_q.push_back(wdata);
                    end else begin
                        w_wait = 1; w_prev = wdata; w_n++;
                    end
                end

                while (aw_q.size() > 0 && w_q.size() > 0) begin
                    a = aw_q.pop_front();
                    d = w_q.pop_front();
                    if (exp_q.size() == 0) begin
                        check_val("sb_unexpected_write", a, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("awaddr", a, e.a);
                        check_val("wdata", d, e.d);
                    end
                    pend_new++;
                end
            end
        end
    end

    initial begin : p_main
        int          t0, t1, t;
        int          wrap_seq[5];
        logic [79:0] pd;
        wrap_seq[0] = 1; wrap_seq[1] = 2; wrap_seq[2] = 3; wrap_seq[3] = 0; wrap_seq[4] = 1;

        do_reset();

        // Single packet then a back-to-back second one for accept-to-accept timing
        fsb_send(80'hABCD_1234_5678_9ABC_DEF0);
        t0 = acc_cyc;
        t  = 0;
        while (!fsb_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("t1_pkt1", pkt_cnt, 32'd1);
        check_val("t1_slot1", 32'(slot_idx), 32'd1);
        fsb_send(80'h0123_4567_89AB_CDEF_0F1E);
        t1 = acc_cyc;
        fsb_v = 1'b0;
        check_val("t1_acc_to_acc", 32'(t1 - t0), 32'd9);
        wait_done("t1");

        aw_lat = 3;
        fsb_send(80'h1111_2222_3333_4444_5555);
        fsb_v = 1'b0;
        wait_done("skew_aw");
        aw_lat = 0;
        w_lat  = 3;
        fsb_send(80'h6666_7777_8888_9999_AAAA);
        fsb_v = 1'b0;
        wait_done("skew_w");
        w_lat = 0;

        do_reset();
        for (int i = 0; i < 5; i++) begin
            pd = {16'hC000 + 16'(i), 32'h1000_0000 + 32'(i), 32'hF000_0000 + 32'(i)};
            fsb_send(pd);
            fsb_v = 1'b0;
            wait_done("wrap");
            check_val("wrap_slot_seq", 32'(slot_idx), 32'(wrap_seq[i]));
        end
        check_val("wrap_pkt5", pkt_cnt, 32'd5);

        add_bresp(2'b00); add_bresp(2'b10); add_bresp(2'b00); add_bresp(2'b10);
        fsb_send(80'hE000_E111_E222_E333_E444);
        fsb_v = 1'b0;
        wait_done("err");
        check_val("err_two", 32'(err_cnt), 32'd2);
        check_val("err_pkt", pkt_cnt, 32'd6);

        @(negedge clk);
        force dut.r_err_cnt = 16'hFFFF;
        #1;
        release dut.r_err_cnt;
        m_err = 16'hFFFF;
        @(negedge clk);
        check_val("sat_forced", 32'(err_cnt), 32'h0000_FFFF);
        add_bresp(2'b10);
        fsb_send(80'h5A5A_A5A5_5A5A_A5A5_5A5A);
        fsb_v = 1'b0;
        wait_done("sat");
        check_val("sat_hold", 32'(err_cnt), 32'h0000_FFFF);

        aw_lat = 1;
        b_lat  = 2;
        fsb_send(80'hB0B0_0000_1111_2222_3333);
        fsb_send(80'hB1B1_4444_5555_6666_7777);
        fsb_send(80'hB2B2_8888_9999_AAAA_BBBB);
        fsb_v = 1'b0;
        wait_done("bp");
        aw_lat = 0;
        b_lat  = 0;

        t1 = b_total + 2;
        fsb_send(80'hDEAD_BEEF_CAFE_F00D_1234);
        fsb_v = 1'b0;
        t = 0;
        while (b_total < t1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("mid_b_reached", 32'(b_total >= t1), 32'd1);
        do_reset();
        fsb_send(80'h0F0F_0E0E_0D0D_0C0C_0B0B);
        fsb_v = 1'b0;
        wait_done("post_rst");
        check_val("post_rst_pkt", pkt_cnt, 32'd1);
        check_val("post_rst_slot", 32'(slot_idx), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
